load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage fed by the execute datapath. Takes the byte address (`ALUResult`) and store data (`RD2`), then runs an aligned word-bus transaction to data memory, splitting misaligned accesses into two beats. Stalls the core until the access completes, then returns sign- or zero-extended load data for the writeback `Result` mux.

## Interface
- `D_WIDTH`, 32, data and address width (fixed at 32 for RV32I)
- `CLK` in 1: single clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `MemRead` in 1: load request, level
- `MemWrite` in 1: store request, level; wins if both requests are high
- `Funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; others decode as word
- `ALUResult` in 32: byte address
- `WriteData` in 32: store data (`RD2`), low bytes used
- `ReadData` out 32: extended load result, held until the next access is accepted
- `Stall` out 1: freezes PC and pipeline inputs
- `Done` out 1: one-cycle pulse on completion
- `MemReq` out 1: bus request
- `MemWe` out 1: 1 for a write beat
- `MemAddr` out 32: word address, bits [1:0] always 0
- `MemWData` out 32: byte-lane-positioned store data
- `MemBe` out 4: byte enables
- `MemGnt` in 1: request accepted this cycle
- `MemRValid` in 1: read data valid; never arrives in the same cycle as its grant
- `MemRData` in 32: read word

## Operation
- FSM states: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- **IDLE:** accepts the access if `MemRead|MemWrite`.
  - Registers address, size, sign and data.
  - `off = addr[1:0]`; bytes = 1, 2 or 4.
  - `split = off + bytes > 4`.
  - Goes to REQ0.
- **REQ0:** drives beat 0.
  - Address `addr & ~3`.
  - `MemBe = (mask << off)[3:0]`.
  - `MemWData = WriteData << 8*off`.
- **Leaving REQ0 on `MemGnt`:**
  - Write: to REQ1 if split, else DONE.
  - Read: to RSP0.
- **RSP0:** on `MemRValid`, captures the enabled bytes, then goes to REQ1 if split, else DONE.
- **REQ1/RSP1:** same pattern for beat 1.
  - Address `(addr & ~3) + 4`, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0.
  - `MemBe = mask >> (4-off)`.
  - `MemWData = WriteData >> 8*(4-off)`.
- **DONE:** `Done=1`, `ReadData` valid, `Stall=0`; unconditionally returns to IDLE. A request seen in DONE is the old instruction and is ignored.
- **Load assembly:** byte `i` of the result comes from lane `(off+i) mod 4` of beat 0, or of beat 1 once past the lane-3 boundary. The result is then extended to 32 bits per `Funct3`.
- **Bus rules:** `MemReq` and all bus outputs are registered. They stay stable while `MemReq=1 && !MemGnt`.
- **Reset:** asynchronous `RST_N` low at any point forces IDLE immediately.
  - Reset values: `MemReq`, `MemWe`, `MemAddr`, `MemWData`, `MemBe`, `ReadData` and `Done` are all 0.
  - `Stall` is forced 0 while in reset.
  - An aborted access produces no `Done`.

## Timing
- `Stall = (IDLE && request) || state ∈ {REQ0, RSP0, REQ1, RSP1}`. This is combinational from state and inputs.
- Latency from acceptance (cycle 0), with zero-wait grant and `MemRValid` one cycle after grant:

| Access | `Done` cycle | `Stall` high |
|---|---|---|
| Aligned write | 2 | cycles 0–1 |
| Aligned read | 3 | cycles 0–2 |
| Split write | 3 | cycles 0–2 |
| Split read | 5 | cycles 0–4 |

- Each extra cycle of `MemGnt` or `MemRValid` wait adds exactly one cycle.
- `ReadData` updates on the edge into DONE. It is unchanged by writes.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_t` enum
  - size/sign decode constants for `Funct3`
  - `LSU_BYTE`, `LSU_HALF`, `LSU_WORD`
- Sub-module `load_formatter`: combinational. Takes the two captured beats, the offset, the size and the sign, and produces `ReadData`.
- FSM, beat generation and capture registers live in `load_store_unit`.

## Test plan
Memory preload: 0x100 = 0x8877_6655, 0x104 = 0xCCBB_AA99.

- LW 0x100, immediate grant → one beat with `MemAddr` 0x100, `MemBe` 1111; `ReadData` 0x8877_6655; `Done` at cycle 3.
- LB 0x103 → `ReadData` 0xFFFF_FF88; LBU 0x103 → 0x0000_0088; LHU 0x102 → 0x0000_8877.
- LW 0x102 → beats 0x100/`MemBe` 1100 and 0x104/`MemBe` 0011; `ReadData` 0xAA99_8877; `Done` at cycle 5.
- SH 0x103 with data 0x0000_1234 → beat 0x100/`MemBe` 1000/`MemWData` 0x3400_0000, then beat 0x104/`MemBe` 0001/`MemWData` 0x0000_0012.
- `MemGnt` held low 4 cycles on SW 0x0FC → `MemReq`, `MemAddr` and `MemWData` stable throughout; `Stall` high throughout; `Done` exactly once.
- `RST_N` pulsed low during RSP1 of a split LW → same cycle: IDLE, `MemReq` 0, `Stall` 0; no `Done`; a new LW after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared state encoding and Funct3 decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1,
        DONE
    } lsu_state_t;

    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have SB/SH/SW, so the unsigned load encodings mean word for a store.
    function automatic logic [1:0] decode_size(input logic [2:0] funct3, input logic is_store);
        logic [1:0] size;
        size = LSU_WORD;
        if (funct3 == F3_B || (!is_store && funct3 == F3_BU)) begin
            size = LSU_BYTE;
        end else if (funct3 == F3_H || (!is_store && funct3 == F3_HU)) begin
            size = LSU_HALF;
        end
        return size;
    endfunction

    function automatic logic decode_unsigned(input logic [2:0] funct3);
        return (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            LSU_BYTE: return 4'b0001;
            LSU_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
        case (size)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return off == 2'd3;
            default:  return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load assembly: picks the addressed bytes out of one or two
// captured bus words and sign- or zero-extends them.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] raw;
    logic [2:0]  lane;

    // Byte i lives at lane off+i; lanes 4..7 spill into the second word.
    always_comb begin
        raw  = '0;
        lane = '0;
        for (int i = 0; i < 4; i++) begin
            lane = {1'b0, off} + 3'(i);
            if (lane[2]) begin
                raw[8*i +: 8] = beat1[8*lane[1:0] +: 8];
            end else begin
                raw[8*i +: 8] = beat0[8*lane[1:0] +: 8];
            end
        end
    end

    always_comb begin
        case (size)
            LSU_BYTE: data = {{24{!is_unsigned && raw[7]}}, raw[7:0]};
            LSU_HALF: data = {{16{!is_unsigned && raw[15]}}, raw[15:0]};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: turns a byte-addressed load/store into one or two aligned
// word-bus beats, stalling the core until the access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         Funct3,
    input  logic [D_WIDTH-1:0] ALUResult,
    input  logic [D_WIDTH-1:0] WriteData,
    output logic [D_WIDTH-1:0] ReadData,
    output logic               Stall,
    output logic               Done,
    output logic               MemReq,
    output logic               MemWe,
    output logic [D_WIDTH-1:0] MemAddr,
    output logic [D_WIDTH-1:0] MemWData,
    output logic [3:0]         MemBe,
    input  logic               MemGnt,
    input  logic               MemRValid,
    input  logic [D_WIDTH-1:0] MemRData
);

    lsu_state_t state_q, state_d;

    logic [D_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [D_WIDTH-1:0] beat0_q, beat0_d;
    logic [D_WIDTH-1:0] read_data_q, read_data_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic               write_q, write_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [D_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;

    logic               request;
    logic               split;
    logic               load_beat1;
    logic [1:0]         req_off;
    logic [1:0]         req_size;
    logic [2:0]         hi_shift;
    logic [D_WIDTH-1:0] fmt_beat0;
    logic [D_WIDTH-1:0] fmt_data;

    assign request   = MemRead | MemWrite;
    assign req_off   = ALUResult[1:0];
    assign req_size  = decode_size(Funct3, MemWrite);
    assign split     = crosses_word(addr_q[1:0], size_q);
    assign hi_shift  = 3'd4 - {1'b0, addr_q[1:0]};
    // Data for an unsplit load is still on the bus when the formatter needs it.
    assign fmt_beat0 = (state_q == RSP0) ? MemRData : beat0_q;

    load_formatter u_formatter (
        .beat0      (fmt_beat0),
        .beat1      (MemRData),
        .off        (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(unsigned_q),
        .data       (fmt_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat0_q     <= '0;
            read_data_q <= '0;
            size_q      <= LSU_WORD;
            unsigned_q  <= 1'b0;
            write_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beat0_q     <= beat0_d;
            read_data_q <= read_data_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            write_q     <= write_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (request) state_d = REQ0;
            REQ0: if (MemGnt) state_d = !write_q ? RSP0 : (split ? REQ1 : DONE);
            RSP0: if (MemRValid) state_d = split ? REQ1 : DONE;
            REQ1: if (MemGnt) state_d = write_q ? DONE : RSP1;
            RSP1: if (MemRValid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus registers hold their value until a grant, keeping the beat stable while waiting.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat0_d     = beat0_q;
        read_data_d = read_data_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        write_d     = write_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        load_beat1  = 1'b0;
        case (state_q)
            IDLE: if (request) begin
                addr_d      = ALUResult;
                wdata_d     = WriteData;
                size_d      = req_size;
                unsigned_d  = decode_unsigned(Funct3);
                write_d     = MemWrite;
                mem_req_d   = 1'b1;
                mem_we_d    = MemWrite;
                mem_addr_d  = {ALUResult[D_WIDTH-1:2], 2'b00};
                mem_be_d    = size_mask(req_size) << req_off;
                mem_wdata_d = WriteData << {req_off, 3'b000};
            end
            REQ0: if (MemGnt) begin
                if (write_q && split) begin
                    load_beat1 = 1'b1;
                end else begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            RSP0: if (MemRValid) begin
                beat0_d = MemRData;
                if (split) begin
                    load_beat1 = 1'b1;
                end else begin
                    read_data_d = fmt_data;
                end
            end
            REQ1: if (MemGnt) begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
            RSP1: if (MemRValid) read_data_d = fmt_data;
            default: ;
        endcase
        if (load_beat1) begin
            mem_req_d   = 1'b1;
            mem_we_d    = write_q;
            mem_addr_d  = {addr_q[D_WIDTH-1:2], 2'b00} + D_WIDTH'(4);
            mem_be_d    = size_mask(size_q) >> hi_shift;
            mem_wdata_d = wdata_q >> {hi_shift, 3'b000};
        end
    end

    always_comb begin
        Stall = 1'b0;
        Done  = 1'b0;
        case (state_q)
            IDLE:                   Stall = request;
            REQ0, RSP0, REQ1, RSP1: Stall = 1'b1;
            DONE:                   Done  = 1'b1;
            default: ;
        endcase
        if (!RST_N) Stall = 1'b0;
    end

    assign ReadData = read_data_q;
    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemBe    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-level
// memory model with a configurable-latency bus responder.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;

    load_store_unit #(.D_WIDTH(32)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Funct3   (Funct3),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Stall    (Stall),
        .Done     (Done),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemBe    (MemBe),
        .MemGnt   (MemGnt),
        .MemRValid(MemRValid),
        .MemRData (MemRData)
    );

    always #5 CLK = ~CLK;

    int vectorCount = 0;
    int missCount   = 0;

    logic [7:0]  refMem [logic [31:0]];
    logic [31:0] busMem [logic [31:0]];
    logic [31:0] lastLoad;

    int          obsBeats;
    logic [31:0] obsAddr  [2];
    logic [3:0]  obsBe    [2];
    logic        obsWe    [2];
    logic [31:0] obsWData [2];
    logic [31:0] obsReadData;
    int          obsDoneCycle;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] initWord(input logic [31:0] wa);
        if (wa == 32'h100) return 32'h8877_6655;
        if (wa == 32'h104) return 32'hCCBB_AA99;
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        logic [31:0] w;
        if (refMem.exists(a)) return refMem[a];
        w = initWord({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] busRead(input logic [31:0] wa);
        if (busMem.exists(wa)) return busMem[wa];
        return initWord(wa);
    endfunction

    task automatic busWrite(input logic [31:0] wa, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] w;
        w = busRead(wa);
        for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = data[8*l +: 8];
        busMem[wa] = w;
    endtask

    task automatic applyStimulus(input logic isWrite, input logic bothReq, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntWait, input int rvWait);
        int          nBytes, nb, expDone, idx;
        int          doneCount, stallBad, stableBad, waitCnt, rvCount;
        bit          beatOpen, rvPending, expStall;
        logic [31:0] base, b, wa, rvAddr, val, mask;
        logic [31:0] expAddr [2];
        logic [3:0]  expBe   [2];
        logic [31:0] expData [2];
        logic [31:0] snapAddr, snapWData;
        logic [3:0]  snapBe;
        logic        snapWe;

        if (isWrite) nBytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else nBytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;

        base = {addr[31:2], 2'b00};
        nb = 1;
        val = '0;
        for (int i = 0; i < 2; i++) begin
            expAddr[i] = '0; expBe[i] = '0; expData[i] = '0;
        end
        for (int k = 0; k < nBytes; k++) begin
            b = addr + 32'(k);
            wa = {b[31:2], 2'b00};
            idx = (wa == base) ? 0 : 1;
            if (idx == 1) nb = 2;
            expAddr[idx] = wa;
            expBe[idx][b[1:0]] = 1'b1;
            expData[idx][8*b[1:0] +: 8] = wdata[8*k +: 8];
            if (isWrite) refMem[b] = wdata[8*k +: 8];
            else val[8*k +: 8] = refByte(b);
        end
        if (!isWrite) begin
            if (nBytes == 1 && f3 == 3'd0) val = {{24{val[7]}}, val[7:0]};
            if (nBytes == 2 && f3 == 3'd1) val = {{16{val[15]}}, val[15:0]};
            lastLoad = val;
        end
        if (isWrite) expDone = (nb == 1) ? 2 + gntWait : 3 + 2*gntWait;
        else expDone = (nb == 1) ? 3 + gntWait + rvWait : 5 + 2*gntWait + 2*rvWait;

        doneCount = 0; stallBad = 0; stableBad = 0; waitCnt = 0; rvCount = 0;
        beatOpen = 0; rvPending = 0; rvAddr = '0; obsBeats = 0; obsDoneCycle = -1;
        obsReadData = 'x;
        snapAddr = '0; snapWData = '0; snapBe = '0; snapWe = 1'b0;

        @(negedge CLK);
        MemRead = !isWrite || bothReq;
        MemWrite = isWrite;
        Funct3 = f3;
        ALUResult = addr;
        WriteData = wdata;

        for (int c = 0; c < expDone + 20; c++) begin
            if (c > 0) @(negedge CLK);
            if (doneCount > 0) begin
                MemRead = 1'b0;
                MemWrite = 1'b0;
            end
            MemGnt = 1'b0;
            MemRValid = 1'b0;
            if (rvPending) begin
                if (rvCount == 0) begin
                    MemRValid = 1'b1;
                    MemRData = busRead(rvAddr);
                    rvPending = 0;
                end else rvCount--;
            end
            if (MemReq === 1'b1) begin
                if (!beatOpen) begin
                    beatOpen = 1; waitCnt = 0;
                    snapAddr = MemAddr; snapWData = MemWData; snapBe = MemBe; snapWe = MemWe;
                end else if (MemAddr !== snapAddr || MemWData !== snapWData ||
                             MemBe !== snapBe || MemWe !== snapWe) begin
                    stableBad++;
                end
                if (waitCnt == gntWait) begin
                    MemGnt = 1'b1;
                    if (obsBeats < 2) begin
                        obsAddr[obsBeats] = MemAddr; obsBe[obsBeats] = MemBe;
                        obsWe[obsBeats] = MemWe; obsWData[obsBeats] = MemWData;
                    end
                    obsBeats++;
                    if (MemWe) busWrite(MemAddr, MemWData, MemBe);
                    else begin
                        rvPending = 1; rvCount = rvWait; rvAddr = MemAddr;
                    end
                    beatOpen = 0;
                end else waitCnt++;
            end
            #1;
            expStall = (c < expDone);
            if (Stall !== expStall) stallBad++;
            if (Done === 1'b1) begin
                if (doneCount == 0) obsDoneCycle = c;
                doneCount++;
                obsReadData = ReadData;
            end else if (doneCount > 0 && c == obsDoneCycle + 1) begin
                checkOutput("idle_memreq", {31'b0, MemReq}, 32'h0);
                break;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; MemGnt = 1'b0; MemRValid = 1'b0;

        checkOutput("done_count", doneCount, 1);
        checkOutput("done_cycle", obsDoneCycle, expDone);
        checkOutput("stall_profile", stallBad, 0);
        checkOutput("bus_stable", stableBad, 0);
        checkOutput("beat_count", obsBeats, nb);
        for (int i = 0; i < nb; i++) begin
            if (i < obsBeats) begin
                checkOutput($sformatf("beat%0d_addr", i), obsAddr[i], expAddr[i]);
                checkOutput($sformatf("beat%0d_be", i), {28'b0, obsBe[i]}, {28'b0, expBe[i]});
                checkOutput($sformatf("beat%0d_we", i), {31'b0, obsWe[i]}, {31'b0, isWrite});
                if (isWrite) begin
                    mask = {{8{expBe[i][3]}}, {8{expBe[i][2]}}, {8{expBe[i][1]}}, {8{expBe[i][0]}}};
                    checkOutput($sformatf("beat%0d_wdata", i), obsWData[i] & mask, expData[i]);
                end
            end
        end
        checkOutput("read_data", obsReadData, lastLoad);
    endtask

    initial begin
        int doneSeen;
        RST_N = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = '0; ALUResult = '0;
        WriteData = '0; MemGnt = 1'b0; MemRValid = 1'b0; MemRData = '0; lastLoad = '0;

        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset_stall", {31'b0, Stall}, 32'h0);
        checkOutput("reset_memreq", {31'b0, MemReq}, 32'h0);
        checkOutput("reset_memwe", {31'b0, MemWe}, 32'h0);
        checkOutput("reset_memaddr", MemAddr, 32'h0);
        checkOutput("reset_memwdata", MemWData, 32'h0);
        checkOutput("reset_membe", {28'b0, MemBe}, 32'h0);
        checkOutput("reset_readdata", ReadData, 32'h0);
        checkOutput("reset_done", {31'b0, Done}, 32'h0);
        MemRead = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
        checkOutput("lw100_data", obsReadData, 32'h8877_6655);
        checkOutput("lw100_addr", obsAddr[0], 32'h100);
        checkOutput("lw100_be", {28'b0, obsBe[0]}, 32'hF);
        checkOutput("lw100_done", obsDoneCycle, 3);

        applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0);
        checkOutput("lb103", obsReadData, 32'hFFFF_FF88);
        applyStimulus(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0);
        checkOutput("lbu103", obsReadData, 32'h0000_0088);
        applyStimulus(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 0, 0);
        checkOutput("lhu102", obsReadData, 32'h0000_8877);

        applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0);
        checkOutput("lw102_data", obsReadData, 32'hAA99_8877);
        checkOutput("lw102_addr0", obsAddr[0], 32'h100);
        checkOutput("lw102_be0", {28'b0, obsBe[0]}, 32'hC);
        checkOutput("lw102_addr1", obsAddr[1], 32'h104);
        checkOutput("lw102_be1", {28'b0, obsBe[1]}, 32'h3);
        checkOutput("lw102_done", obsDoneCycle, 5);

        applyStimulus(1'b1, 1'b0, 3'b001, 32'h103, 32'h0000_1234, 0, 0);
        checkOutput("sh103_be0", {28'b0, obsBe[0]}, 32'h8);
        checkOutput("sh103_wdata0", obsWData[0], 32'h3400_0000);
        checkOutput("sh103_be1", {28'b0, obsBe[1]}, 32'h1);
        checkOutput("sh103_wdata1", obsWData[1], 32'h0000_0012);

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0FC, 32'hDEAD_BEEF, 4, 0);
        checkOutput("sw_wait_done", obsDoneCycle, 6);

        applyStimulus(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1, 1);
        checkOutput("wrap_addr1", obsAddr[1], 32'h0);

        // Reset pulse while the second read beat is outstanding.
        @(negedge CLK);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h102;
        @(negedge CLK);
        MemGnt = 1'b1;
        @(negedge CLK);
        MemGnt = 1'b0; MemRValid = 1'b1; MemRData = busRead(32'h100);
        @(negedge CLK);
        MemRValid = 1'b0; MemGnt = 1'b1;
        @(negedge CLK);
        MemGnt = 1'b0;
        #1;
        checkOutput("rsp1_stall", {31'b0, Stall}, 32'h1);
        checkOutput("rsp1_memreq", {31'b0, MemReq}, 32'h0);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("abort_memreq", {31'b0, MemReq}, 32'h0);
        checkOutput("abort_stall", {31'b0, Stall}, 32'h0);
        checkOutput("abort_done", {31'b0, Done}, 32'h0);
        checkOutput("abort_readdata", ReadData, 32'h0);
        MemRead = 1'b0;
        lastLoad = '0;
        doneSeen = 0;
        repeat (2) begin
            @(negedge CLK); #1;
            if (Done !== 1'b0) doneSeen++;
        end
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK); #1;
            if (Done !== 1'b0) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic        isW, both;
            logic [2:0]  f3;
            logic [31:0] a;
            isW = 1'($urandom_range(0, 1));
            both = isW && ($urandom_range(0, 3) == 0);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else a = 32'h0000_00F0 + 32'($urandom_range(0, 47));
            applyStimulus(isW, both, f3, a, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
